// File: rtl/cfg_frame_loader_if.sv
// Serial configuration bus between a bitstream source and cfg_frame_loader.
// The loader takes the slave side.
interface cfg_frame_loader_if #(
    parameter int CFG_W = 176
);
    logic             reg_in;
    logic             reg_en;
    logic             cfg_clr;
    logic             reg_out;
    logic [CFG_W-1:0] prog;
    logic             busy;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output reg_in, reg_en, cfg_clr,
        input  reg_out, prog, busy, cfg_done, cfg_err
    );

    modport slave (
        input  reg_in, reg_en, cfg_clr,
        output reg_out, prog, busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/cfg_frame_loader.sv
// Serial frame loader: sync hunt, ID filter, payload shift into a shadow register,
// and an even-parity gated atomic commit to prog. The stream is daisy-chained on reg_out.
module cfg_frame_loader #(
    parameter int               CFG_W     = 176,
    parameter int               ID_W      = 4,
    parameter logic [ID_W-1:0]  BLOCK_ID  = '0,
    parameter int               SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
    parameter logic [CFG_W-1:0] RESET_CFG = '0
) (
    input logic               reg_clk,
    input logic               reg_nres,
    cfg_frame_loader_if.slave bus
);
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] ID_LAST  = CNT_W'(ID_W - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(CFG_W - 1);

    typedef enum logic [1:0] {S_HUNT, S_ID, S_PAYLOAD, S_PARITY} state_t;

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] win_q, win_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              matched_q, matched_d;
    logic [CFG_W-1:0]  shadow_q, shadow_d;
    logic [CFG_W-1:0]  prog_q, prog_d;
    logic              reg_out_q, reg_out_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              err_set;
    logic [ID_W:0]     id_shift;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        matched_d = matched_q;
        shadow_d  = shadow_q;
        prog_d    = prog_q;
        reg_out_d = reg_out_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_set   = 1'b0;
        id_shift  = {id_q, bus.reg_in};

        if (bus.reg_en) begin
            reg_out_d = bus.reg_in;
            unique case (state_q)
                S_HUNT: begin
                    win_d = {win_q[SYNC_W-2:0], bus.reg_in};
                    if (win_d == SYNC_PAT) begin
                        state_d = S_ID;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                S_ID: begin
                    id_d  = id_shift[ID_W-1:0];
                    par_d = par_q ^ bus.reg_in;
                    if (cnt_q == ID_LAST) begin
                        matched_d = (id_d == BLOCK_ID) || (&id_d);
                        state_d   = S_PAYLOAD;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PAYLOAD: begin
                    if (matched_q) shadow_d = {shadow_q[CFG_W-2:0], bus.reg_in};
                    par_d = par_q ^ bus.reg_in;
                    if (cnt_q == PAY_LAST) begin
                        state_d = S_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (matched_q) begin
                        if ((par_q ^ bus.reg_in) == 1'b0) begin
                            prog_d = shadow_q;
                            done_d = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                    // A following frame must present a complete fresh sync word.
                    state_d = S_HUNT;
                    win_d   = '0;
                end
                default: state_d = S_HUNT;
            endcase
        end

        if (bus.cfg_clr) err_d = 1'b0;
        if (err_set)     err_d = 1'b1;
    end

    always_ff @(posedge reg_clk or negedge reg_nres) begin
        if (!reg_nres) begin
            state_q   <= S_HUNT;
            win_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            matched_q <= 1'b0;
            shadow_q  <= '0;
            prog_q    <= RESET_CFG;
            reg_out_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            matched_q <= matched_d;
            shadow_q  <= shadow_d;
            prog_q    <= prog_d;
            reg_out_q <= reg_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.reg_out  = reg_out_q;
    assign bus.prog     = prog_q;
    assign bus.busy     = (state_q != S_HUNT);
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader: a table of whole frames with expected results,
// plus hand-written reset, noise and back-to-back sequences.
module tb_cfg_frame_loader;
    localparam int CFG_W  = 176;
    localparam int ID_W   = 4;
    localparam int SYNC_W = 8;
    localparam int FL     = SYNC_W + ID_W + CFG_W + 1;
    localparam logic [SYNC_W-1:0] SYNC = 8'hA5;

    logic clk;
    logic rst_n;
    cfg_frame_loader_if #(.CFG_W(CFG_W)) bus();

    cfg_frame_loader #(
        .CFG_W(CFG_W), .ID_W(ID_W), .BLOCK_ID(4'h0),
        .SYNC_W(SYNC_W), .SYNC_PAT(8'hA5), .RESET_CFG('0)
    ) dut (
        .reg_clk (clk),
        .reg_nres(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   ro_bad = 0;
    int   done_cnt = 0;
    logic last_bit = 1'b0;
    bit   have_prev = 0;

    always @(negedge clk) if (bus.cfg_done === 1'b1) done_cnt++;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [CFG_W-1:0] pay;
        bit               flip;
        bit               stall;
        bit               clr_after;
        logic [CFG_W-1:0] exp_prog;
        int               exp_done;
        logic             exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        if (have_prev && bus.reg_out !== last_bit) ro_bad++;
        bus.reg_in = b;
        bus.reg_en = 1'b1;
        last_bit   = b;
        have_prev  = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (have_prev && bus.reg_out !== last_bit) ro_bad++;
            bus.reg_en = 1'b0;
            bus.reg_in = 1'($urandom);
        end
    endtask

    task automatic send_frame(input logic [ID_W-1:0] id, input logic [CFG_W-1:0] pay,
                              input bit flip, input bit stall, input int nbits);
        logic [FL-1:0] fr;
        logic          p;
        p  = ^{id, pay};
        fr = {SYNC, id, pay, p ^ flip};
        for (int i = 0; i < nbits; i++) begin
            if (stall && (i < SYNC_W || i == FL - 1 || $urandom_range(0, 4) == 0))
                idle($urandom_range(1, 3));
            send_bit(fr[FL-1-i]);
        end
    endtask

    logic [CFG_W-1:0] P1, P3, P4, P5, P6, B1, B2;
    int d0;

    initial begin
        P1 = 176'hFFFF0000696980804040202010100808040402020101;
        P3 = {11{16'h1234}};
        P4 = {16'hFFFF, 144'h0, 16'h0001};
        P5 = {11{16'hC3E1}};
        P6 = {22{8'hA5}};
        B1 = {88{2'b01}};
        B2 = {88{2'b10}};

        vecs[0] = '{4'h0, P1, 0, 0, 0, P1, 1, 1'b0};
        vecs[1] = '{4'h3, P3, 0, 0, 0, P1, 0, 1'b0};
        vecs[2] = '{4'hF, P3, 0, 0, 0, P3, 1, 1'b0};
        vecs[3] = '{4'h0, P4, 1, 0, 1, P3, 0, 1'b1};
        vecs[4] = '{4'h0, P5, 0, 1, 0, P5, 1, 1'b0};
        vecs[5] = '{4'h0, P6, 0, 0, 0, P6, 1, 1'b0};
        vecs[6] = '{4'h2, P1, 0, 1, 0, P6, 0, 1'b0};

        rst_n       = 1'b0;
        bus.reg_in  = 1'b0;
        bus.reg_en  = 1'b0;
        bus.cfg_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_prog", bus.prog, '0);
        chk("rst_busy", CFG_W'(bus.busy), '0);
        chk("rst_err", CFG_W'(bus.cfg_err), '0);
        chk("rst_done", CFG_W'(bus.cfg_done), '0);
        chk("rst_reg_out", CFG_W'(bus.reg_out), '0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            send_frame(vecs[i].id, vecs[i].pay, vecs[i].flip, vecs[i].stall, FL);
            idle(3);
            chk($sformatf("v%0d_prog", i), bus.prog, vecs[i].exp_prog);
            chk($sformatf("v%0d_done", i), CFG_W'(done_cnt - d0), CFG_W'(vecs[i].exp_done));
            chk($sformatf("v%0d_err", i), CFG_W'(bus.cfg_err), CFG_W'(vecs[i].exp_err));
            chk($sformatf("v%0d_busy", i), CFG_W'(bus.busy), '0);
            if (vecs[i].clr_after) begin
                @(negedge clk) bus.cfg_clr = 1'b1;
                @(negedge clk) bus.cfg_clr = 1'b0;
                chk($sformatf("v%0d_clr", i), CFG_W'(bus.cfg_err), '0);
            end
        end

        // Leading noise 1010 before the sync word must not disturb lock.
        d0 = done_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_frame(4'h0, P3, 0, 0, FL);
        idle(3);
        chk("noise_prog", bus.prog, P3);
        chk("noise_done", CFG_W'(done_cnt - d0), CFG_W'(1));

        // Back-to-back frames with no idle gap.
        d0 = done_cnt;
        send_frame(4'h0, B1, 0, 0, FL);
        send_frame(4'h0, B2, 0, 0, FL);
        idle(3);
        chk("b2b_done", CFG_W'(done_cnt - d0), CFG_W'(2));
        chk("b2b_prog", bus.prog, B2);

        // Reset landing in the middle of a payload, with cfg_err set beforehand.
        send_frame(4'h0, P4, 1, 0, FL);
        idle(2);
        chk("pre_rst_err", CFG_W'(bus.cfg_err), CFG_W'(1));
        send_frame(4'h0, P5, 0, 0, SYNC_W + ID_W + 50);
        idle(1);
        chk("mid_busy", CFG_W'(bus.busy), CFG_W'(1));
        @(negedge clk);
        bus.reg_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_prog", bus.prog, '0);
        chk("mid_rst_busy", CFG_W'(bus.busy), '0);
        chk("mid_rst_err", CFG_W'(bus.cfg_err), '0);
        have_prev = 0;
        @(negedge clk) rst_n = 1'b1;
        d0 = done_cnt;
        send_frame(4'h0, P1, 0, 0, FL);
        idle(3);
        chk("post_rst_prog", bus.prog, P1);
        chk("post_rst_done", CFG_W'(done_cnt - d0), CFG_W'(1));

        chk("reg_out_chain", CFG_W'(ro_bad), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Serial configuration loader for the parametrised next-generation switch/logic tile.
- Replaces the directly driven parallel prog bus. Receives framed, ID-addressed, parity-protected bitstreams on the reg_in chain and daisy-chains the stream to the next tile.
- Atomically commits a validated payload to the tile's active prog register through a shadow register.

Parameters:
- CFG_W, 176, payload/prog width in bits.
- ID_W, 4, tile address field width.
- BLOCK_ID, 0, this tile's address. All-ones ID is broadcast.
- SYNC_W, 8, sync pattern width.
- SYNC_PAT, 8'hA5, frame sync pattern.
- RESET_CFG, 0 (CFG_W bits), prog value after reset.

Ports:
- reg_clk  input  1  sole clock; all state changes on the rising edge.
- reg_nres  input  1  asynchronous active-low reset.
- reg_in  input  1  serial config bit, MSB first.
- reg_en  input  1  bit-valid strobe. reg_in is sampled only when reg_en=1.
- cfg_clr  input  1  synchronous clear of cfg_err.
- reg_out  output  1  daisy-chain output: reg_in registered on each reg_en=1 edge.
- prog  output  CFG_W  active configuration to the tile.
- busy  output  1  high whenever state != HUNT.
- cfg_done  output  1  one-cycle pulse on a successful commit.
- cfg_err  output  1  sticky parity-error flag.

Behaviour:
- Reset (reg_nres=0, asynchronous) forces:
  - prog=RESET_CFG; shadow=0; sync window=0; all counters=0.
  - state=HUNT; reg_out=0; cfg_done=0; cfg_err=0; matched=0.
  - Reset mid-frame abandons the frame. prog does not change except to RESET_CFG.
- Stall: edges with reg_en=0 hold all state, counters and reg_out. The cfg_done pulse still clears after one cycle.
- Frame format, MSB first: SYNC_W sync bits, then ID_W ID bits, then CFG_W payload bits, then 1 parity bit. Total length = SYNC_W+ID_W+CFG_W+1 (189 bits at defaults).
- Parity is even over ID+payload+parity: the total number of ones must be even.
- HUNT:
  - Shift reg_in into the SYNC_W-bit sliding window.
  - When the updated window equals SYNC_PAT, go to ID with the bit counter at 0 on the same edge.
  - Overlapping sync candidates are allowed.
- ID:
  - Collect ID_W bits.
  - On the last ID bit, latch matched = (id==BLOCK_ID) or (id==all-ones), then go to PAYLOAD.
- PAYLOAD:
  - If matched, shift each bit into shadow; the first payload bit ends at shadow[CFG_W-1].
  - If not matched, shadow holds.
  - After CFG_W bits, go to PARITY.
  - The counter is clog2(CFG_W+1) bits wide and is never compared against SYNC_PAT. Sync-like data inside a frame is ignored.
- PARITY, on the edge sampling the parity bit:
  - If matched and parity is OK: prog<=shadow, and cfg_done=1 for the following cycle.
  - If matched and parity fails: cfg_err<=1; prog is unchanged.
  - If not matched: no effect.
  - In all cases, return to HUNT with the window cleared. A back-to-back frame must begin with a full fresh sync.
- The running parity accumulator resets on entry to ID.
- cfg_clr=1 clears cfg_err. If a parity failure lands on the same edge, the set wins.
- prog never takes partial values. It changes only at a commit or at reset.
- reg_out always follows reg_in with 1-bit latency whenever reg_en=1, regardless of state or ID match.

Test Plan:
1. Reset: assert reg_nres=0 mid-PAYLOAD (bit 50) -> prog=0, busy=0, cfg_err=0 immediately. A subsequent full frame commits normally.
2. Unicast commit with BLOCK_ID=0:
   - Send A5, ID 0, payload 176'hFFFF0000696980804040202010100808040402020101, correct parity.
   - -> prog equals the payload after the parity edge; cfg_done high exactly 1 cycle; busy low afterwards.
3. Address filter:
   - Same frame with ID 3 -> prog unchanged, cfg_done=0, cfg_err=0. reg_out reproduces all 189 bits delayed 1 cycle.
   - ID F (broadcast) -> commits.
4. Parity error:
   - Frame with payload 176'hFFFF...0001 and flipped parity -> prog keeps the previous value, cfg_err=1 and stays 1.
   - Then cfg_clr=1 for 1 cycle -> cfg_err=0.
5. Stalls and sync aliasing:
   - Random reg_en=0 gaps, including during sync and parity -> identical commit result.
   - Payload containing A5 bytes -> no resync.
   - Leading noise 0xA then A5 -> locks on the A5.
6. Back-to-back:
   - Two frames with payloads 176'h...5555 then 176'h...AAAA, no gap -> two cfg_done pulses; final prog=...AAAA.
